keypad_row_scanner: RTL

//  Avalon-MM slave output port that drives keypad row lines; successor to the fixed 4-bit row PIO.
//  - Parametrised row count; atomic SET/CLEAR writes.
//  - Hardware auto-scan mode: walks a one-hot row pattern with a programmable dwell time.
//  - Exports row index and sample strobe to the column-sampling logic.

---
 rtl/keypad_row_pkg.sv | 25 ++
 rtl/keypad_row_scanner_if.sv | 22 ++
 rtl/keypad_row_scan_fsm.sv | 77 +++++++
 rtl/keypad_row_scanner.sv | 129 ++++++++++++
 4 files changed

// File: rtl/keypad_row_pkg.sv
// Keypad row scanner shared definitions: register map,
// CTRL/STATUS bit positions and scan FSM states.
package keypad_row_pkg;

  localparam int ADDR_W = 3;
  localparam int BUS_W  = 32;

  localparam logic [ADDR_W-1:0] REG_DATA   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_CTRL   = 3'd1;
  localparam logic [ADDR_W-1:0] REG_DIV    = 3'd2;
  localparam logic [ADDR_W-1:0] REG_STATUS = 3'd3;
  localparam logic [ADDR_W-1:0] REG_OUTSET = 3'd4;
  localparam logic [ADDR_W-1:0] REG_OUTCLR = 3'd5;

  localparam int CTRL_SCAN_EN  = 0;
  localparam int CTRL_ACT_LOW  = 1;
  localparam int CTRL_IRQ_MASK = 2;
  localparam int STAT_WRAP     = 8;

  typedef enum logic {
    IDLE,
    DRIVE
  } scan_state_e;

endpackage

// File: rtl/keypad_row_scanner_if.sv
// Avalon-MM slave bus bundle for the keypad row scanner
// (zero wait states, combinational read data).
interface keypad_row_scanner_if;
  import keypad_row_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/keypad_row_scan_fsm.sv
// Auto-scan engine: dwell counter, row index and state, with
// look-ahead registered strobe and wrap pulses.
module keypad_row_scan_fsm
  import keypad_row_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int DIV_W = 16,
  parameter int RW    = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_en,
  input  logic [DIV_W-1:0] div,
  output logic             drive,
  output logic [RW-1:0]    row,
  output logic             strobe,
  output logic             wrap_set
);

  scan_state_e      state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;
  logic             wrap_set_q, wrap_set_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = DRIVE;
          row_d   = '0;
          cnt_d   = div;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          cnt_d = div;
          row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (!scan_en) begin
          state_d = IDLE;
          row_d   = '0;
        end
      end
    endcase
    // Pulses are computed for the next cycle so they leave a flop
    strobe_d   = (state_d == DRIVE) && (cnt_d == '0);
    wrap_set_d = strobe_d && (row_d == RW'(ROWS - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      wrap_set_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
      wrap_set_q <= wrap_set_d;
    end
  end

  assign drive    = (state_q == DRIVE);
  assign row      = row_q;
  assign strobe   = strobe_q;
  assign wrap_set = wrap_set_q;

endmodule

// File: rtl/keypad_row_scanner.sv
// Keypad row drive port with SET/CLEAR writes and auto-scan.
// Define KEYPAD_ROW_SCAN_IRQ_EN to add the wrap interrupt.
module keypad_row_scanner
  import keypad_row_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 999
) (
  input  logic                     clk,
  input  logic                     reset_n,
  keypad_row_scanner_if.slave      bus,
  output logic [ROWS-1:0]          out_port,
  output logic [$clog2(ROWS)-1:0]  scan_row,
  output logic                     scan_strobe
`ifdef KEYPAD_ROW_SCAN_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int RW = $clog2(ROWS);

  logic [ROWS-1:0]  data_q, data_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap_q, wrap_d;
  logic             wr_en;
  logic             drive;
  logic             wrap_set;
  logic [ROWS-1:0]  pat;
  logic [BUS_W-1:0] rdata;
  logic             unused_wd;

  assign unused_wd = ^bus.writedata;

  keypad_row_scan_fsm #(
    .ROWS  (ROWS),
    .DIV_W (DIV_W),
    .RW    (RW)
  ) u_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .scan_en  (ctrl_q[CTRL_SCAN_EN]),
    .div      (div_q),
    .drive    (drive),
    .row      (scan_row),
    .strobe   (scan_strobe),
    .wrap_set (wrap_set)
  );

  always_comb begin
    wr_en  = bus.chipselect & ~bus.write_n;
    data_d = data_q;
    ctrl_d = ctrl_q;
    div_d  = div_q;
    wrap_d = wrap_q;
    if (wr_en) begin
      case (bus.address)
        REG_DATA:   data_d = bus.writedata[ROWS-1:0];
        REG_CTRL: begin
          ctrl_d[CTRL_SCAN_EN] = bus.writedata[CTRL_SCAN_EN];
          ctrl_d[CTRL_ACT_LOW] = bus.writedata[CTRL_ACT_LOW];
`ifdef KEYPAD_ROW_SCAN_IRQ_EN
          ctrl_d[CTRL_IRQ_MASK] = bus.writedata[CTRL_IRQ_MASK];
`endif
        end
        REG_DIV:    div_d = bus.writedata[DIV_W-1:0];
        REG_STATUS: if (bus.writedata[STAT_WRAP]) wrap_d = 1'b0;
        REG_OUTSET: data_d = data_q | bus.writedata[ROWS-1:0];
        REG_OUTCLR: data_d = data_q & ~bus.writedata[ROWS-1:0];
        default: ;
      endcase
    end
    // A wrap landing with a W1C keeps the flag set
    if (wrap_set) wrap_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
      ctrl_q <= '0;
      div_q  <= DIV_W'(RESET_DIV);
      wrap_q <= 1'b0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      div_q  <= div_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef KEYPAD_ROW_SCAN_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = wrap_d & ctrl_d[CTRL_IRQ_MASK];

  always_ff @(posedge clk) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    case (bus.address)
      REG_DATA:   rdata[ROWS-1:0]  = data_q;
      REG_CTRL:   rdata[2:0]       = ctrl_q;
      REG_DIV:    rdata[DIV_W-1:0] = div_q;
      REG_STATUS: begin
        rdata[RW-1:0]    = scan_row;
        rdata[STAT_WRAP] = wrap_q;
      end
      default: ;
    endcase
  end

  assign bus.readdata = rdata;

  // Manual value shows only while idle; polarity applies to scan only
  always_comb begin
    pat = ROWS'(1) << scan_row;
    if (drive) out_port = ctrl_q[CTRL_ACT_LOW] ? ~pat : pat;
    else       out_port = data_q;
  end

endmodule
